// File: rtl/cic_comb_decimator.sv
// rtl/cic_comb_decimator.sv - CIC decimator comb section: rate counter, comb chain, truncating output
module cic_comb_decimator #(
   parameter int DATA_WIDTH_INP = 16,
   parameter int DATA_WIDTH_OUT = 12,
   parameter int STAGES         = 3,
   parameter int DECIMATION     = 4,
   parameter int DIFF_DELAY     = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic signed [DATA_WIDTH_INP-1:0]  inp_samp_data,
   input  logic                              inp_samp_str,
   output logic signed [DATA_WIDTH_OUT-1:0]  out_samp_data,
   output logic                              out_samp_str
);

   localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECIMATION - 1);

   // Rate counter; a strobe is taken only when it sees the counter at zero
   logic [CNT_W-1:0] dec_cnt;
   logic             accept;

   // Index 0 is the registered accepted sample, index k is the output of comb stage k
   logic signed [DATA_WIDTH_INP-1:0] stage_data [0:STAGES];
   logic                             stage_vld  [0:STAGES];

   // Per-stage differential delay line; entry 0 is the newest stage input
   logic signed [DATA_WIDTH_INP-1:0] dly [0:STAGES-1][0:DIFF_DELAY-1];

   assign accept = inp_samp_str && (dec_cnt == '0);

   // Decimation counter advances on every strobe and wraps at DECIMATION-1
   always_ff @(posedge clk) begin
      if (reset) begin
         dec_cnt <= '0;
      end else if (inp_samp_str) begin
         if (dec_cnt == CNT_MAX) begin
            dec_cnt <= '0;
         end else begin
            dec_cnt <= dec_cnt + 1'b1;
         end
      end
   end

   // Capture accepted samples into the stage-0 register
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_data[0] <= '0;
         stage_vld[0]  <= 1'b0;
      end else begin
         stage_vld[0] <= accept;
         if (accept) begin
            stage_data[0] <= inp_samp_data;
         end
      end
   end

   // Comb chain: each stage subtracts its input from DIFF_DELAY valid samples ago.
   // Subtraction wraps at DATA_WIDTH_INP bits so integrator overflow cancels out.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= STAGES; k++) begin
            stage_data[k] <= '0;
            stage_vld[k]  <= 1'b0;
         end
         for (int k = 0; k < STAGES; k++) begin
            for (int i = 0; i < DIFF_DELAY; i++) begin
               dly[k][i] <= '0;
            end
         end
      end else begin
         for (int k = 1; k <= STAGES; k++) begin
            stage_vld[k] <= stage_vld[k-1];
            if (stage_vld[k-1]) begin
               stage_data[k] <= stage_data[k-1] - dly[k-1][DIFF_DELAY-1];
               dly[k-1][0]   <= stage_data[k-1];
               for (int i = 1; i < DIFF_DELAY; i++) begin
                  dly[k-1][i] <= dly[k-1][i-1];
               end
            end
         end
      end
   end

   // The final stage register only loads on valid, so the output holds between strobes
   assign out_samp_data = $signed(stage_data[STAGES][DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT]);
   assign out_samp_str  = stage_vld[STAGES];

   // Low-order bits are dropped by the MSB-aligned truncation
   logic unused_final_bits;
   assign unused_final_bits = ^stage_data[STAGES];

endmodule

// File: tb/tb_cic_comb_decimator.sv
// tb/tb_cic_comb_decimator.sv - directed bench for cic_comb_decimator
module tb_cic_comb_decimator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   // impulse / throughput: W=8, N=2, R=1, M=1
   logic              rst_imp, str_imp, ostr_imp;
   logic signed [7:0] din_imp, dout_imp;
   // decimation: W=16, N=1, R=4, M=1
   logic               rst_dec, str_dec, ostr_dec;
   logic signed [15:0] din_dec, dout_dec;
   // wrap: W=8, N=1, R=1, M=1
   logic              rst_wrp, str_wrp, ostr_wrp;
   logic signed [7:0] din_wrp, dout_wrp;
   // differential delay 2: W=8, N=1, R=1, M=2
   logic              rst_m2, str_m2, ostr_m2;
   logic signed [7:0] din_m2, dout_m2;
   // latency / truncation / reset: W=12, O=8, N=3, R=1, M=1
   logic               rst_lat, str_lat, ostr_lat;
   logic signed [11:0] din_lat;
   logic signed [7:0]  dout_lat;

   cic_comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(2), .DECIMATION(1), .DIFF_DELAY(1)) u_imp (
      .clk(clk), .reset(rst_imp), .inp_samp_data(din_imp), .inp_samp_str(str_imp),
      .out_samp_data(dout_imp), .out_samp_str(ostr_imp));
   cic_comb_decimator #(.DATA_WIDTH_INP(16), .DATA_WIDTH_OUT(16), .STAGES(1), .DECIMATION(4), .DIFF_DELAY(1)) u_dec (
      .clk(clk), .reset(rst_dec), .inp_samp_data(din_dec), .inp_samp_str(str_dec),
      .out_samp_data(dout_dec), .out_samp_str(ostr_dec));
   cic_comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(1), .DECIMATION(1), .DIFF_DELAY(1)) u_wrp (
      .clk(clk), .reset(rst_wrp), .inp_samp_data(din_wrp), .inp_samp_str(str_wrp),
      .out_samp_data(dout_wrp), .out_samp_str(ostr_wrp));
   cic_comb_decimator #(.DATA_WIDTH_INP(8), .DATA_WIDTH_OUT(8), .STAGES(1), .DECIMATION(1), .DIFF_DELAY(2)) u_m2 (
      .clk(clk), .reset(rst_m2), .inp_samp_data(din_m2), .inp_samp_str(str_m2),
      .out_samp_data(dout_m2), .out_samp_str(ostr_m2));
   cic_comb_decimator #(.DATA_WIDTH_INP(12), .DATA_WIDTH_OUT(8), .STAGES(3), .DECIMATION(1), .DIFF_DELAY(1)) u_lat (
      .clk(clk), .reset(rst_lat), .inp_samp_data(din_lat), .inp_samp_str(str_lat),
      .out_samp_data(dout_lat), .out_samp_str(ostr_lat));

   // Output capture: value and cycle of every output strobe
   int q_imp[$], c_imp[$], q_dec[$], c_dec[$], q_wrp[$], q_m2[$], q_lat[$], c_lat[$];
   always @(negedge clk) begin
      if (ostr_imp) begin q_imp.push_back(int'(dout_imp)); c_imp.push_back(cyc); end
      if (ostr_dec) begin q_dec.push_back(int'(dout_dec)); c_dec.push_back(cyc); end
      if (ostr_wrp) q_wrp.push_back(int'(dout_wrp));
      if (ostr_m2)  q_m2.push_back(int'(dout_m2));
      if (ostr_lat) begin q_lat.push_back(int'(dout_lat)); c_lat.push_back(cyc); end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -99999;
   endfunction

   int t0, t1;

   initial begin
      rst_imp = 1; rst_dec = 1; rst_wrp = 1; rst_m2 = 1; rst_lat = 1;
      str_imp = 0; str_dec = 0; str_wrp = 0; str_m2 = 0; str_lat = 0;
      din_imp = 0; din_dec = 0; din_wrp = 0; din_m2 = 0; din_lat = 0;
      repeat (3) tick();
      chk("reset_str_lat",  int'(ostr_lat), 0);
      chk("reset_data_lat", int'(dout_lat), 0);
      chk("reset_str_dec",  int'(ostr_dec), 0);
      chk("reset_data_imp", int'(dout_imp), 0);
      rst_imp = 0; rst_dec = 0; rst_wrp = 0; rst_m2 = 0; rst_lat = 0;
      tick();

      // Impulse through two combs at full rate
      t0 = cyc; din_imp = 1; str_imp = 1; tick();
      din_imp = 0; tick(); tick(); tick();
      str_imp = 0; repeat (6) tick();
      chk("imp_count", q_imp.size(), 4);
      chk("imp_y0", qget(q_imp, 0), 1);
      chk("imp_y1", qget(q_imp, 1), -2);
      chk("imp_y2", qget(q_imp, 2), 1);
      chk("imp_y3", qget(q_imp, 3), 0);
      for (int i = 0; i < 4; i++) chk($sformatf("imp_cycle%0d", i), qget(c_imp, i) - t0, 3 + i);

      // Ramp 0..15 with R=4
      t0 = cyc;
      for (int i = 0; i < 16; i++) begin din_dec = 16'(i); str_dec = 1; tick(); end
      str_dec = 0; repeat (4) tick();
      chk("dec_count", q_dec.size(), 4);
      chk("dec_y0", qget(q_dec, 0), 0);
      chk("dec_y1", qget(q_dec, 1), 4);
      chk("dec_y2", qget(q_dec, 2), 4);
      chk("dec_y3", qget(q_dec, 3), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("dec_cycle%0d", i), qget(c_dec, i) - t0, 4 * i + 2);
      chk("dec_hold", int'(dout_dec), 4);

      // Gapped strobes: counter holds across idle cycles; accepts 100 and 200
      din_dec = 100; str_dec = 1; tick();
      str_dec = 0; tick();
      din_dec = 1; str_dec = 1; tick();
      str_dec = 0; tick();
      din_dec = 2; str_dec = 1; tick();
      din_dec = 3; tick();
      t1 = cyc; din_dec = 200; tick();
      str_dec = 0; repeat (4) tick();
      chk("dec_gap_count", q_dec.size(), 6);
      chk("dec_gap_y4", qget(q_dec, 4), 88);
      chk("dec_gap_y5", qget(q_dec, 5), 100);
      chk("dec_gap_lat", qget(c_dec, 5) - t1, 2);

      // Reset with simultaneous strobe: strobe must not count; next strobe accepted, delay reads 0
      rst_dec = 1; din_dec = 77; str_dec = 1; tick();
      rst_dec = 0; str_dec = 0; tick();
      chk("dec_rst_str", int'(ostr_dec), 0);
      chk("dec_rst_data", int'(dout_dec), 0);
      t1 = cyc; din_dec = 50; str_dec = 1; tick();
      str_dec = 0; repeat (4) tick();
      chk("dec_rst_count", q_dec.size(), 7);
      chk("dec_rst_y", qget(q_dec, 6), 50);
      chk("dec_rst_lat", qget(c_dec, 6) - t1, 2);

      // Two's-complement wrap
      din_wrp = 8'sd127; str_wrp = 1; tick();
      din_wrp = -8'sd128; tick();
      str_wrp = 0; repeat (4) tick();
      chk("wrap_count", q_wrp.size(), 2);
      chk("wrap_y0", qget(q_wrp, 0), 127);
      chk("wrap_y1", qget(q_wrp, 1), 1);

      // M=2 with gaps: delay line shifts only on valid
      din_m2 = 5; str_m2 = 1; tick();
      str_m2 = 0; tick();
      din_m2 = 7; str_m2 = 1; tick();
      str_m2 = 0; tick(); tick();
      din_m2 = 10; str_m2 = 1; tick();
      din_m2 = 20; tick();
      str_m2 = 0; repeat (4) tick();
      chk("m2_count", q_m2.size(), 4);
      chk("m2_y0", qget(q_m2, 0), 5);
      chk("m2_y1", qget(q_m2, 1), 7);
      chk("m2_y2", qget(q_m2, 2), 5);
      chk("m2_y3", qget(q_m2, 3), 13);
      chk("m2_hold", int'(dout_m2), 13);
      chk("m2_idle_str", int'(ostr_m2), 0);

      // Latency and MSB truncation, N=3
      t0 = cyc; din_lat = 12'h0F0; str_lat = 1; tick();
      str_lat = 0; repeat (6) tick();
      chk("lat_count", q_lat.size(), 1);
      chk("lat_y", qget(q_lat, 0), 15);
      chk("lat_cycles", qget(c_lat, 0) - t0, 4);
      chk("lat_hold", int'(dout_lat), 15);

      // Mid-pipeline reset drops in-flight samples
      din_lat = 12'h100; str_lat = 1; tick();
      din_lat = 12'h200; tick();
      rst_lat = 1; din_lat = 12'h7F0; tick();
      rst_lat = 0; str_lat = 0; tick();
      chk("midrst_str", int'(ostr_lat), 0);
      chk("midrst_data", int'(dout_lat), 0);
      repeat (6) tick();
      chk("midrst_no_stale", q_lat.size(), 1);
      t0 = cyc; din_lat = 12'h050; str_lat = 1; tick();
      str_lat = 0; repeat (6) tick();
      chk("midrst_count", q_lat.size(), 2);
      chk("midrst_y", qget(q_lat, 1), 5);
      chk("midrst_lat", qget(c_lat, 1) - t0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cic_comb_decimator.md
CIC_COMB_DECIMATOR -- requirements
Module: cic_comb_decimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH_INP, default 16, giving the input and internal comb width in bits.
REQ-002 SHALL have parameter DATA_WIDTH_OUT, default 12, giving the output width in bits; legal range is 1 to DATA_WIDTH_INP.
REQ-003 SHALL have parameter STAGES, default 3, giving the number of comb stages; legal value is 1 or more.
REQ-004 SHALL have parameter DECIMATION, default 4, giving the rate change factor R; legal value is 1 or more.
REQ-005 SHALL have parameter DIFF_DELAY, default 1, giving the differential delay M; legal value is 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port inp_samp_data, input, signed [DATA_WIDTH_INP-1:0]: the integrator-chain output sample.
REQ-009 SHALL have port inp_samp_str, input, 1 bit: input sample strobe, valid for one clk.
REQ-010 SHALL have port out_samp_data, output, signed [DATA_WIDTH_OUT-1:0]: the decimated comb output.
REQ-011 SHALL have port out_samp_str, output, 1 bit: output strobe, a one-clk pulse per output sample.

Function
REQ-012 SHALL hold a decimation counter running from 0 to DECIMATION-1; the counter increments on each inp_samp_str and wraps to 0 after DECIMATION-1.
REQ-013 SHALL accept an input sample only when inp_samp_str=1 and the counter=0; the first strobe after reset is accepted, then every DECIMATION-th strobe after it.
REQ-014 SHALL ignore inp_samp_data whenever inp_samp_str=0; the counter holds its value in that case.
REQ-015 SHALL register each accepted sample into the stage-0 input register one clk after acceptance, together with a valid bit.
REQ-016 SHALL make each comb stage k compute y = x - x_d, where x_d is the stage input from DIFF_DELAY accepted samples earlier.
REQ-017 SHALL implement each stage's delay line as DIFF_DELAY registers that shift only on that stage's input valid.
REQ-018 SHALL register each stage output, so its valid bit reaches the next stage exactly one clk later.
REQ-019 SHALL perform all subtraction at DATA_WIDTH_INP bits in two's complement, modulo 2^DATA_WIDTH_INP, with wrap and no saturation; this cancels integrator overflow.
REQ-020 SHALL set out_samp_data to final-stage bits [DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT], truncating MSB-aligned with no rounding.
REQ-021 SHALL pulse out_samp_str high for exactly one clk, STAGES+1 clks after the clk in which a sample is accepted.
REQ-022 SHALL hold out_samp_data stable between out_samp_str pulses.
REQ-023 SHALL sustain full throughput with DECIMATION=1 and back-to-back strobes: one output per clk, no stalls, no dropped samples.
REQ-024 SHALL fix out_samp_str latency regardless of input strobe spacing; there is no backpressure.

Reset
REQ-025 SHALL, on any clk edge with reset=1, clear the decimation counter, all delay lines, all stage registers and all valid bits to 0.
REQ-026 SHALL drive out_samp_str=0 and out_samp_data=0 from the first clk edge with reset=1 until new data propagates.
REQ-027 SHALL discard in-flight samples on a reset mid-operation; no out_samp_str is produced for samples accepted before the reset.
REQ-028 SHALL give reset priority over a simultaneous inp_samp_str; that strobe is neither counted nor accepted.

Verification
REQ-029 SHALL pass an impulse test with R=1, N=2, M=1 and 8-bit width: inputs 1,0,0,0 on consecutive strobes -> outputs 1,-2,1,0.
REQ-030 SHALL pass a decimation test with R=4, N=1, M=1: ramp inputs 0..15 with one strobe per clk -> 4 output strobes with data 0,4,4,4.
REQ-031 SHALL pass a wrap test with width 8, R=1, N=1: inputs 127 then -128 -> second output is +1.
REQ-032 SHALL pass a latency and truncation test with N=3, DATA_WIDTH_INP=12, DATA_WIDTH_OUT=8: single strobe with 0x0F0 -> out_samp_str exactly 4 clks later, data 0x0F.
REQ-033 SHALL pass a mid-operation reset test: reset for 1 clk while samples are in the pipeline -> no stale out_samp_str; the next strobe is accepted as counter=0, with delay lines reading 0.
